// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the pulse stretcher: FSM state encoding,
// hold/gap counter width and the per-state counter reload value.
package pulse_stretcher_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    typedef logic [CNT_W-1:0] cnt_t;

    // Counter value loaded on entry to a state; the count runs down to zero,
    // so a state lasting N cycles is loaded with N-1.
    function automatic cnt_t reload_value(
        input state_e      s,
        input int unsigned hold_cycles,
        input int unsigned gap_cycles
    );
        case (s)
            HOLD:    return CNT_W'(hold_cycles - 1);
            GAP:     return CNT_W'(gap_cycles - 1);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/stretch_timer.sv
// Reloadable 8-bit down-counter; tc_c flags the last cycle of the loaded interval.
module stretch_timer
    import pulse_stretcher_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  cnt_t load_val,
    output logic tc_c
);

    cnt_t count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc_c = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle pulses into HOLD_CYCLES-wide levels separated by
// GAP_CYCLES low cycles, queueing pulses that arrive while busy.
// Define PULSE_STRETCHER_RETRIGGER_EN to make pulses during HOLD extend the level.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter  int unsigned HOLD_CYCLES = 4,
    parameter  int unsigned GAP_CYCLES  = 2,
    parameter  int unsigned QUEUE_DEPTH = 3,
    localparam int unsigned PEND_W      = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    output logic              level_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    localparam bit RETRIGGER = 1'b1;
`else
    localparam bit RETRIGGER = 1'b0;
`endif

    state_e            state_q;
    state_e            state_d;
    logic [PEND_W-1:0] pending_d;
    logic              overflow_d;
    logic              queue_req_c;
    logic              retrig_c;
    logic              timer_load_c;
    cnt_t              timer_val_c;
    logic              tc_c;

    stretch_timer u_timer (
        .clk      (clk),
        .rst_n    (rst),
        .load     (timer_load_c),
        .load_val (timer_val_c),
        .tc_c     (tc_c)
    );

    // Next-state, queue bookkeeping and timer control
    always_comb begin
        state_d     = state_q;
        pending_d   = pending;
        overflow_d  = overflow;
        queue_req_c = 1'b0;
        retrig_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pulse_in) state_d = HOLD;
            end
            HOLD: begin
                if (RETRIGGER && pulse_in) begin
                    retrig_c = 1'b1;
                end else begin
                    queue_req_c = pulse_in;
                    if (tc_c) state_d = GAP;
                end
            end
            GAP: begin
                if (!tc_c) begin
                    queue_req_c = pulse_in;
                end else if (pending != '0) begin
                    // Dequeue one; a coincident pulse takes the freed slot.
                    state_d   = HOLD;
                    pending_d = pending - PEND_W'(1) + PEND_W'(pulse_in);
                end else if (pulse_in) begin
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (queue_req_c) begin
            if (pending < PEND_W'(QUEUE_DEPTH)) begin
                pending_d = pending + PEND_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end

        timer_load_c = (state_d != state_q) || retrig_c;
        timer_val_c  = reload_value(state_d, HOLD_CYCLES, GAP_CYCLES);
    end

    // State and registered outputs, derived from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            level_out <= 1'b0;
            busy      <= 1'b0;
            pending   <= '0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_out <= (state_d == HOLD);
            busy      <= (state_d != IDLE);
            pending   <= pending_d;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: directed per-cycle vectors push
// expected outputs, an independent monitor pops and compares each cycle.
module tb_pulse_stretcher;

    localparam int unsigned PEND_W = 2;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              pulse_in = 1'b0;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    typedef struct {
        string name;
        logic  level;
        logic  busy;
        int    pend;
        logic  ovf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pulse_stretcher dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .level_out (level_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    function automatic logic bit_at(input string s, input int i);
        byte b;
        if (i >= s.len()) return 1'b0;
        b = s[i];
        return (b == 8'd49);
    endfunction

    function automatic int digit_at(input string s, input int i);
        byte b;
        if (i >= s.len()) return 0;
        b = s[i];
        return int'(b) - 48;
    endfunction

    task automatic check(input string what, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", what, act, req);
        end
    endtask

    // Cycle c: inputs driven 2ns after the edge that starts it, outputs
    // checked at the following negedge. Two reset cycles precede each test.
    task automatic run_test(input string name, input string pul, input string rs,
                            input string lvl, input string bsy, input string pnd,
                            input string ovf);
        exp_t e;
        logic drop;
        for (int c = -2; c < lvl.len(); c++) begin
            @(posedge clk);
            #2;
            drop = 1'b0;
            e.name = $sformatf("%s@%0d", name, c);
            if (c < 0) begin
                rst      = 1'b0;
                pulse_in = 1'b0;
                e.level  = 1'b0;
                e.busy   = 1'b0;
                e.pend   = 0;
                e.ovf    = 1'b0;
            end else begin
                if (rs.len() > 0 && !bit_at(rs, c)) drop = 1'b1;
                else rst = 1'b1;
                pulse_in = bit_at(pul, c);
                e.level  = bit_at(lvl, c);
                e.busy   = bit_at(bsy, c);
                e.pend   = digit_at(pnd, c);
                e.ovf    = bit_at(ovf, c);
            end
            exp_q.push_back(e);
            if (drop) begin
                #1;
                rst = 1'b0;
            end
        end
        pulse_in = 1'b0;
    endtask

    // Monitor: compares every presented cycle against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, " level_out"}, int'(level_out), int'(e.level));
                check({e.name, " busy"},      int'(busy),      int'(e.busy));
                check({e.name, " pending"},   int'(pending),   e.pend);
                check({e.name, " overflow"},  int'(overflow),  int'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        run_test("single", "1000000000", "",
                 "0111100000", "0111111000", "0000000000", "0000000000");
`ifndef PULSE_STRETCHER_RETRIGGER_EN
        run_test("queue3", "10110000000000000000", "",
                 "01111001111001111000", "01111111111111111110",
                 "00012221111110000000", "00000000000000000000");
        run_test("overflow", "111110000000000000000000000", "",
                 "011110011110011110011110000", "011111111111111111111111100",
                 "001233322222211111100000000", "000001111111111111111111111");
        run_test("reset_mid", "111110000100000000", "111111110111111111",
                 "011110010011110000", "011111110011111100",
                 "001233320000000000", "000001110000000000");
`else
        run_test("retrigger", "100100000000", "",
                 "011111110000", "011111111100", "000000000000", "000000000000");
`endif
        run_test("gap_pulse", "100000100000000", "",
                 "011110011110000", "011111111111100",
                 "000000000000000", "000000000000000");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, the number of cycles level_out is high per accepted pulse (legal range 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, the number of low cycles forced between consecutive stretched pulses (legal range 1..255).
REQ-003 SHALL have parameter QUEUE_DEPTH, default 3, the maximum number of pending pulses held (legal range 1..15).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port pulse_in, input, 1 bit: single-cycle pulse, the output of a button shaper.
REQ-007 SHALL have port level_out, output, 1 bit: stretched level.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port pending, output, width $clog2(QUEUE_DEPTH+1): count of queued pulses.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag for a dropped pulse.

Function
REQ-011 SHALL sample pulse_in on the rising edge of clk, and all outputs SHALL be registered.
REQ-012 SHALL implement the states IDLE, HOLD and GAP.
REQ-013 In IDLE with pulse_in=1, SHALL go to HOLD next cycle, with level_out rising one cycle after the sampling edge.
REQ-014 In HOLD, level_out SHALL be high for exactly HOLD_CYCLES cycles, then the state SHALL go to GAP.
REQ-015 In GAP, level_out SHALL be low for exactly GAP_CYCLES cycles.
REQ-016 On the last GAP cycle, the next state SHALL be chosen as follows:
- pending>0: go to HOLD; pending becomes pending-1+pulse_in.
- pending=0 and pulse_in=1: go to HOLD; pending stays 0.
- otherwise: go to IDLE.
REQ-017 pulse_in=1 in HOLD, or in GAP other than its last cycle, SHALL increment pending when pending<QUEUE_DEPTH.
REQ-018 A pulse arriving when pending=QUEUE_DEPTH and no decrement occurs that cycle SHALL be dropped and SHALL set overflow; overflow SHALL be cleared only by reset.
REQ-019 pending SHALL never exceed QUEUE_DEPTH or wrap below 0.
REQ-020 pulse_in held high for N cycles SHALL be treated as N pulses (no edge detection inside this block).
REQ-021 The hold/gap counter SHALL be 8 bits and SHALL reload on every state entry.

Reset
REQ-022 rst=0 SHALL immediately force state=IDLE, level_out=0, busy=0, pending=0, overflow=0 and counter=0, regardless of clk.
REQ-023 Reset asserted mid-HOLD SHALL drop level_out within the same cycle, and no queued pulse SHALL survive the reset.
REQ-024 The first pulse_in sampled after rst deasserts SHALL be handled as a pulse in IDLE.

Configuration
REQ-025 When macro PULSE_STRETCHER_RETRIGGER_EN is defined, pulse_in=1 during HOLD SHALL reload the hold counter to HOLD_CYCLES (extending the level) and SHALL NOT increment pending; pulses in GAP SHALL still queue.
REQ-026 When PULSE_STRETCHER_RETRIGGER_EN is undefined, behaviour SHALL be exactly REQ-017.

Structure
REQ-027 Package pulse_stretcher_pkg SHALL hold the state enum (IDLE, HOLD, GAP) and the counter width constant (8).
REQ-028 The reloadable down-counter with a terminal-count output SHALL be the sub-module stretch_timer, instantiated once.

Verification
REQ-029 Defaults; one pulse at cycle 0 -> level_out high cycles 1..4, low cycles 5..6, busy low from cycle 7, pending=0 throughout.
REQ-030 Defaults; pulses at cycles 0, 2 and 3 -> three 4-cycle highs starting at cycles 1, 7 and 13; pending reads 1, 2, 1, 0 at the corresponding points.
REQ-031 Defaults; 5 pulses during the first HOLD -> pending saturates at 3, overflow=1 after the 5th pulse, and exactly 4 stretched pulses are emitted.
REQ-032 Pulse on the last GAP cycle with pending=0 -> HOLD entered next cycle, no IDLE cycle in between, pending stays 0.
REQ-033 rst driven low mid-HOLD between clock edges -> level_out, busy, pending and overflow read 0 before the next edge.
REQ-034 With PULSE_STRETCHER_RETRIGGER_EN, pulses at cycles 0 and 3 -> level_out high cycles 1..7, single GAP, pending=0.
